// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS R2000 execute stage: ALU op classes, R-type funct codes
// and the multiply/divide sequencer states.
package mips_pkg;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_RSVD  = 2'b11;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [1:0] {IDLE, MUL, DIV, SIGN} md_state_t;

  // mult, multu, div, divu occupy funct 0x18..0x1B
  function automatic logic is_md_funct(input logic [5:0] f);
    return (f[5:2] == 4'b0110);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide: operands are latched as magnitudes, one result bit is
// produced per cycle (shift-add or restoring division), then a single cycle fixes signs.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int MD_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,      // {div, unsigned}
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = (MD_ITER > 1) ? $clog2(MD_ITER) : 1;

  md_state_t          state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [63:0]        acc;
  logic [31:0]        mag_a, mag_b;
  logic               a_neg, b_neg, is_div;

  logic               sgn_in;
  logic [31:0]        mag_a_in, mag_b_in;
  logic [32:0]        mul_sum, div_trial;
  logic [63:0]        mul_step, div_step, prod;
  logic [31:0]        quo, rem, hi_res, lo_res;

  assign sgn_in   = ~op[0];
  assign mag_a_in = (sgn_in & a[31]) ? -a : a;
  assign mag_b_in = (sgn_in & b[31]) ? -b : b;

  assign mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? mag_b : 32'd0)};
  assign mul_step = {mul_sum, acc[31:1]};
  // Upper 33 bits of the shifted {remainder, dividend} pair against the divisor
  assign div_trial = acc[63:31] - {1'b0, mag_b};
  assign div_step  = div_trial[32] ? {acc[62:0], 1'b0} : {div_trial[31:0], acc[30:0], 1'b1};

  always_comb begin
    prod   = (a_neg ^ b_neg) ? -acc : acc;
    quo    = (a_neg ^ b_neg) ? -acc[31:0] : acc[31:0];
    rem    = a_neg ? -acc[63:32] : acc[63:32];
    hi_res = prod[63:32];
    lo_res = prod[31:0];
    if (is_div) begin
      hi_res = rem;
      // A zero divisor leaves the dividend magnitude as remainder; only LO needs forcing
      lo_res = (mag_b == 32'd0) ? 32'hFFFF_FFFF : quo;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      mag_a  <= mag_a_in;
      mag_b  <= mag_b_in;
      a_neg  <= sgn_in & a[31];
      b_neg  <= sgn_in & b[31];
      is_div <= op[1];
      acc    <= {32'd0, mag_a_in};
    end else if (state == MUL) begin
      acc <= mul_step;
    end else if (state == DIV) begin
      acc <= div_step;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      if (start)
        cnt <= CNT_W'(MD_ITER - 1);
      else if (state == MUL || state == DIV)
        cnt <= cnt - CNT_W'(1);
      if (state == SIGN) begin
        hi <= hi_res;
        lo <= lo_res;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = op[1] ? DIV : MUL;
      MUL, DIV: if (cnt == '0) state_nxt = SIGN;
      SIGN:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/ex_stage.sv
// MIPS R2000 execute stage: ALU, branch-target adder, destination mux and EX/MEM register.
// Define MULDIV_EN to build the HI/LO multiply/divide unit and its stall interlock.
module ex_stage
  import mips_pkg::*;
#(
  parameter int MD_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_EX,
  input  logic [1:0]  wb_EX,
  input  logic [2:0]  m_EX,
  input  logic [1:0]  alu_op,
  input  logic        alu_src,
  input  logic        reg_dst,
  input  logic [31:0] read_data1,
  input  logic [31:0] read_data2,
  input  logic [31:0] sign_ext_imm,
  input  logic [31:0] pc_plus4,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  output logic [1:0]  wb_MEM,
  output logic [2:0]  m,
  output logic        zero,
  output logic [31:0] address_MEM,
  output logic [31:0] write_data_mem,
  output logic [4:0]  reg_MEM,
  output logic [31:0] branch_target,
  output logic        stall
);

  logic signed [31:0] op_a, op_b;
  logic [5:0]         funct;
  logic [4:0]         shamt;
  logic               is_r;
  logic [31:0]        alu_result;
  logic [31:0]        bt_sum;
  logic [4:0]         dest;

  assign op_a   = $signed(read_data1);
  assign op_b   = alu_src ? $signed(sign_ext_imm) : $signed(read_data2);
  assign funct  = sign_ext_imm[5:0];
  assign shamt  = sign_ext_imm[10:6];
  assign is_r   = (alu_op == ALU_RTYPE);
  assign bt_sum = pc_plus4 + {sign_ext_imm[29:0], 2'b00};
  assign dest   = reg_dst ? rd : rt;

`ifdef MULDIV_EN
  logic        md_busy, md_start;
  logic [31:0] hi, lo;

  assign md_start = valid_EX & is_r & is_md_funct(funct) & ~md_busy;
  assign stall    = valid_EX & md_busy & is_r &
                    (is_md_funct(funct) | (funct == F_MFHI) | (funct == F_MFLO));

  muldiv_unit #(.MD_ITER(MD_ITER)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (funct[1:0]),
    .a     (read_data1),
    .b     (read_data2),
    .busy  (md_busy),
    .hi    (hi),
    .lo    (lo)
  );
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    alu_result = op_a + op_b;
    if (alu_op == ALU_SUB) begin
      alu_result = op_a - op_b;
    end else if (is_r) begin
      case (funct)
        F_ADD, F_ADDU: alu_result = op_a + op_b;
        F_SUB, F_SUBU: alu_result = op_a - op_b;
        F_AND:         alu_result = op_a & op_b;
        F_OR:          alu_result = op_a | op_b;
        F_XOR:         alu_result = op_a ^ op_b;
        F_NOR:         alu_result = ~(op_a | op_b);
        F_SLT:         alu_result = {31'd0, (op_a < op_b)};
        F_SLTU:        alu_result = {31'd0, ($unsigned(op_a) < $unsigned(op_b))};
        F_SLL:         alu_result = $unsigned(op_b) << shamt;
        F_SRL:         alu_result = $unsigned(op_b) >> shamt;
        F_SRA:         alu_result = op_b >>> shamt;
`ifdef MULDIV_EN
        F_MFHI:        alu_result = hi;
        F_MFLO:        alu_result = lo;
`endif
        default:       alu_result = 32'd0;
      endcase
    end
  end

  // EX -> MEM register boundary; a stalled or invalid slot carries no control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_MEM         <= '0;
      m              <= '0;
      zero           <= 1'b0;
      address_MEM    <= '0;
      write_data_mem <= '0;
      reg_MEM        <= '0;
      branch_target  <= '0;
    end else begin
      wb_MEM         <= (valid_EX && !stall) ? wb_EX : 2'b00;
      m              <= (valid_EX && !stall) ? m_EX  : 3'b000;
      zero           <= (alu_result == 32'd0);
      address_MEM    <= alu_result;
      write_data_mem <= read_data2;
      reg_MEM        <= dest;
      branch_target  <= bt_sum;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed table-driven bench for ex_stage, with hand-written multi-cycle sequences
// for the HI/LO unit (built when MULDIV_EN is defined) and asynchronous reset.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_EX;
  logic [1:0]  wb_EX;
  logic [2:0]  m_EX;
  logic [1:0]  alu_op;
  logic        alu_src;
  logic        reg_dst;
  logic [31:0] read_data1, read_data2, sign_ext_imm, pc_plus4;
  logic [4:0]  rt, rd;
  logic [1:0]  wb_MEM;
  logic [2:0]  m;
  logic        zero;
  logic [31:0] address_MEM, write_data_mem, branch_target;
  logic [4:0]  reg_MEM;
  logic        stall;

  int checks = 0;
  int errors = 0;

  ex_stage #(.MD_ITER(32)) dut (
    .clk(clk), .rst(rst), .valid_EX(valid_EX), .wb_EX(wb_EX), .m_EX(m_EX),
    .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst),
    .read_data1(read_data1), .read_data2(read_data2), .sign_ext_imm(sign_ext_imm),
    .pc_plus4(pc_plus4), .rt(rt), .rd(rd), .wb_MEM(wb_MEM), .m(m), .zero(zero),
    .address_MEM(address_MEM), .write_data_mem(write_data_mem), .reg_MEM(reg_MEM),
    .branch_target(branch_target), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [1:0]  wb;
    logic [2:0]  mc;
    logic [1:0]  op;
    logic        src;
    logic        dst;
    logic [31:0] a, b, imm, pc4;
    logic [4:0]  rt, rd;
    logic [31:0] e_addr, e_bt;
  } vec_t;

  vec_t vt[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_r(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic [1:0] wb);
    valid_EX     = 1'b1;
    wb_EX        = wb;
    m_EX         = 3'b000;
    alu_op       = 2'b10;
    alu_src      = 1'b0;
    reg_dst      = 1'b1;
    read_data1   = a;
    read_data2   = b;
    sign_ext_imm = {26'd0, f};
    pc_plus4     = 32'd0;
    rt           = 5'd0;
    rd           = d;
  endtask

`ifdef MULDIV_EN
  // Issue a mult/div, follow it with mflo (stalls until done), then mfhi
  task automatic md_run(input string nm, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    drive_r(f, a, b, 5'd0, 2'b00);
    #1 check({nm, "_issue_stall"}, {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    drive_r(6'h12, 32'd0, 32'd0, 5'd9, 2'b10);
    #1;
    n = 0;
    while (stall && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) check({nm, "_stall_bubble_wb"}, {30'd0, wb_MEM}, 32'd0);
    end
    check({nm, "_stall_cycles"}, 32'(n), 32'd33);
    @(posedge clk); #1;
    check({nm, "_lo"}, address_MEM, exp_lo);
    check({nm, "_mflo_wb"}, {30'd0, wb_MEM}, 32'd2);
    drive_r(6'h10, 32'd0, 32'd0, 5'd9, 2'b10);
    #1 check({nm, "_mfhi_stall"}, {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check({nm, "_hi"}, address_MEM, exp_hi);
  endtask
`endif

  task automatic check_all_zero(input string nm);
    check({nm, "_wb"},    {30'd0, wb_MEM}, 32'd0);
    check({nm, "_m"},     {29'd0, m}, 32'd0);
    check({nm, "_zero"},  {31'd0, zero}, 32'd0);
    check({nm, "_addr"},  address_MEM, 32'd0);
    check({nm, "_wdata"}, write_data_mem, 32'd0);
    check({nm, "_reg"},   {27'd0, reg_MEM}, 32'd0);
    check({nm, "_bt"},    branch_target, 32'd0);
    check({nm, "_stall"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    // valid wb mc op src dst a b imm pc4 rt rd -> e_addr e_bt
    vt[0]  = '{1'b1, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 32'd7, 32'd5, 32'h20, 32'h1000, 5'd2, 5'd3, 32'd12, 32'h1080};
    vt[1]  = '{1'b1, 2'b00, 3'b100, 2'b01, 1'b0, 1'b0, 32'd9, 32'd9, 32'hFFFF_FFFF, 32'h100, 5'd4, 5'd5, 32'd0, 32'hFC};
    vt[2]  = '{1'b1, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 32'd0, 32'h8000_0000, 32'h103, 32'd0, 5'd6, 5'd7, 32'hF800_0000, 32'h40C};
    vt[3]  = '{1'b1, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h2A, 32'd0, 5'd1, 5'd2, 32'd1, 32'hA8};
    vt[4]  = '{1'b1, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h2B, 32'd0, 5'd1, 5'd2, 32'd0, 32'hAC};
    vt[5]  = '{1'b1, 2'b11, 3'b010, 2'b00, 1'b1, 1'b0, 32'h100, 32'h55, 32'hFFFF_FFF8, 32'h20, 5'd8, 5'd9, 32'hF8, 32'h0};
    vt[6]  = '{1'b1, 2'b00, 3'b001, 2'b00, 1'b1, 1'b0, 32'h200, 32'hDEAD_BEEF, 32'd4, 32'd4, 5'd10, 5'd11, 32'h204, 32'h14};
    vt[7]  = '{1'b1, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 32'd0, 32'd0, 32'h27, 32'd0, 5'd1, 5'd12, 32'hFFFF_FFFF, 32'h9C};
    vt[8]  = '{1'b1, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 32'd0, 32'h8000_0000, 32'h102, 32'd0, 5'd1, 5'd13, 32'h0800_0000, 32'h408};
    vt[9]  = '{1'b1, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 32'd0, 32'd1, 32'h7C0, 32'd0, 5'd1, 5'd14, 32'h8000_0000, 32'h1F00};
    vt[10] = '{1'b1, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 32'd5, 32'd7, 32'h22, 32'd0, 5'd1, 5'd15, 32'hFFFF_FFFE, 32'h88};
    vt[11] = '{1'b1, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 32'd1, 32'd1, 32'h3F, 32'd0, 5'd1, 5'd16, 32'd0, 32'hFC};
    vt[12] = '{1'b0, 2'b11, 3'b111, 2'b00, 1'b0, 1'b1, 32'd1, 32'd2, 32'd0, 32'd0, 5'd1, 5'd17, 32'd3, 32'd0};
    vt[13] = '{1'b1, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 32'hF0F0, 32'hFF00, 32'h24, 32'd0, 5'd1, 5'd18, 32'hF000, 32'h90};
    vt[14] = '{1'b1, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 32'hF0F0, 32'hFF00, 32'h25, 32'd0, 5'd1, 5'd19, 32'hFFF0, 32'h94};
    vt[15] = '{1'b1, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 32'hF0F0, 32'hFF00, 32'h26, 32'd0, 5'd1, 5'd20, 32'h0FF0, 32'h98};
    vt[16] = '{1'b1, 2'b10, 3'b000, 2'b11, 1'b0, 1'b1, 32'd2, 32'd3, 32'd0, 32'd0, 5'd1, 5'd21, 32'd5, 32'd0};
    vt[17] = '{1'b1, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h21, 32'd0, 5'd1, 5'd22, 32'd0, 32'h84};
    vt[18] = '{1'b1, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 32'd0, 32'd1, 32'h23, 32'd0, 5'd1, 5'd23, 32'hFFFF_FFFF, 32'h8C};
    vt[19] = '{1'b1, 2'b10, 3'b000, 2'b10, 1'b0, 1'b1, 32'd0, 32'h7FFF_FFF0, 32'h103, 32'd0, 5'd1, 5'd24, 32'h07FF_FFFF, 32'h40C};

    valid_EX = 1'b0; wb_EX = 2'b00; m_EX = 3'b000; alu_op = 2'b00; alu_src = 1'b0;
    reg_dst = 1'b0; read_data1 = 32'd0; read_data2 = 32'd0; sign_ext_imm = 32'd0;
    pc_plus4 = 32'd0; rt = 5'd0; rd = 5'd0;

    repeat (2) @(posedge clk);
    #1 check_all_zero("reset_hold");
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      valid_EX = vt[i].valid; wb_EX = vt[i].wb; m_EX = vt[i].mc; alu_op = vt[i].op;
      alu_src = vt[i].src; reg_dst = vt[i].dst; read_data1 = vt[i].a; read_data2 = vt[i].b;
      sign_ext_imm = vt[i].imm; pc_plus4 = vt[i].pc4; rt = vt[i].rt; rd = vt[i].rd;
      #1 check($sformatf("v%0d_stall", i), {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      check($sformatf("v%0d_addr", i), address_MEM, vt[i].e_addr);
      check($sformatf("v%0d_zero", i), {31'd0, zero}, {31'd0, (vt[i].e_addr == 32'd0)});
      check($sformatf("v%0d_reg", i), {27'd0, reg_MEM}, {27'd0, (vt[i].dst ? vt[i].rd : vt[i].rt)});
      check($sformatf("v%0d_bt", i), branch_target, vt[i].e_bt);
      check($sformatf("v%0d_wb", i), {30'd0, wb_MEM}, {30'd0, (vt[i].valid ? vt[i].wb : 2'b00)});
      check($sformatf("v%0d_m", i), {29'd0, m}, {29'd0, (vt[i].valid ? vt[i].mc : 3'b000)});
      check($sformatf("v%0d_wdata", i), write_data_mem, vt[i].b);
    end

    // Asynchronous reset in the middle of a cycle clears outputs without a clock edge
    #2 rst = 1'b1;
    #1 check_all_zero("reset_async");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

`ifdef MULDIV_EN
    begin
      int n;
      // Independent instructions keep flowing while the unit is busy
      drive_r(6'h18, 32'd2, 32'd3, 5'd0, 2'b00);
      #1 check("flow_issue_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      drive_r(6'h20, 32'd1, 32'd2, 5'd4, 2'b10);
      #1 check("flow_add_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      check("flow_add_addr", address_MEM, 32'd3);
      check("flow_add_wb", {30'd0, wb_MEM}, 32'd2);
      drive_r(6'h12, 32'd0, 32'd0, 5'd9, 2'b10);
      #1;
      n = 0;
      while (stall && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check("flow_stall_cycles", 32'(n), 32'd32);
      @(posedge clk); #1;
      check("flow_lo", address_MEM, 32'd6);
    end

    md_run("mult_m3x5", 6'h18, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    md_run("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    md_run("div_7by0", 6'h1A, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    md_run("div_m7by2", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md_run("divu_100by7", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14);

    // Reset while multiplying aborts the operation and clears HI/LO
    drive_r(6'h18, 32'd3, 32'd4, 5'd0, 2'b00);
    @(posedge clk); #1;
    drive_r(6'h12, 32'd0, 32'd0, 5'd9, 2'b10);
    repeat (5) @(posedge clk);
    #1 check("rst_md_busy_stall", {31'd0, stall}, 32'd1);
    #2 rst = 1'b1;
    #1 check("rst_md_stall_cleared", {31'd0, stall}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rst_md_lo", address_MEM, 32'd0);
    check("rst_md_mflo_wb", {30'd0, wb_MEM}, 32'd2);
    drive_r(6'h10, 32'd0, 32'd0, 5'd9, 2'b10);
    @(posedge clk); #1;
    check("rst_md_hi", address_MEM, 32'd0);
    check("rst_md_zero", {31'd0, zero}, 32'd1);
`else
    // Without the HI/LO unit these functs decode as unknown and never stall
    drive_r(6'h12, 32'd5, 32'd6, 5'd9, 2'b10);
    #1 check("nomd_mflo_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check("nomd_mflo_addr", address_MEM, 32'd0);
    check("nomd_mflo_wb", {30'd0, wb_MEM}, 32'd2);
    drive_r(6'h18, 32'd3, 32'd4, 5'd0, 2'b00);
    #1 check("nomd_mult_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check("nomd_mult_addr", address_MEM, 32'd0);
    drive_r(6'h10, 32'd3, 32'd4, 5'd9, 2'b10);
    #1 check("nomd_mfhi_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check("nomd_mfhi_addr", address_MEM, 32'd0);
    check("nomd_mfhi_zero", {31'd0, zero}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
